// File: rtl/rs_alu_scheduler_pkg.sv
// rtl/rs_alu_scheduler_pkg.sv - shared sizes and ALU opcode encoding for the ALU reservation station
package rs_alu_scheduler_pkg;

  localparam int RS_DEPTH    = 8;
  localparam int RS_IDX_W    = 3;
  localparam int ROB_ENTRY_W = 4;

  typedef logic [5:0] opcode_t;

  // Opcode values must stay aligned with the ALU's decoder.
  localparam opcode_t ADD   = 6'd0;
  localparam opcode_t SUB   = 6'd1;
  localparam opcode_t AND_OP = 6'd2;
  localparam opcode_t OR_OP = 6'd3;
  localparam opcode_t XOR_OP = 6'd4;
  localparam opcode_t SLL   = 6'd5;
  localparam opcode_t SRL   = 6'd6;
  localparam opcode_t SRA   = 6'd7;
  localparam opcode_t SLT   = 6'd8;
  localparam opcode_t SLTU  = 6'd9;
  localparam opcode_t BEQ   = 6'd10;
  localparam opcode_t BNE   = 6'd11;
  localparam opcode_t BLT   = 6'd12;
  localparam opcode_t BGE   = 6'd13;
  localparam opcode_t JALR  = 6'd14;
  localparam opcode_t S_OP  = 6'd15;

endpackage

// File: rtl/rs_alu_scheduler_picker.sv
// rtl/rs_alu_scheduler_picker.sv - lowest-index priority encoder used for free-slot and issue selection
module rs_ready_picker #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu_scheduler.sv
// rtl/rs_alu_scheduler.sv - ALU reservation station with CDB snooping and single-issue scheduler
module rs_alu_scheduler
  import rs_alu_scheduler_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int IDX_W = RS_IDX_W,
  parameter int ROB_W = ROB_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [5:0]       disp_opcode,
  input  logic             disp_qj_valid,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [31:0]      disp_vj,
  input  logic             disp_qk_valid,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic [31:0]      disp_vk,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic [ROB_W-1:0] disp_rob,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob,
  input  logic [31:0]      cdb_alu_result,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob,
  input  logic [31:0]      cdb_lsb_result,
  output logic             alu_sgn,
  output logic [5:0]       alu_opcode,
  output logic [31:0]      alu_lhs,
  output logic [31:0]      alu_rhs,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_rob
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] qj_valid;
  logic [DEPTH-1:0] qk_valid;
  opcode_t          op_q  [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [31:0]      pc_q  [DEPTH];

  logic [DEPTH-1:0] free_req;
  logic [DEPTH-1:0] ready;
  logic             free_found;
  logic             issue_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] issue_idx;

  assign free_req = ~busy;
  assign ready    = busy & ~qj_valid & ~qk_valid;
  assign rs_full  = ~free_found;

  rs_ready_picker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free_pick (
    .req   (free_req),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_ready_picker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_issue_pick (
    .req   (ready),
    .found (issue_found),
    .idx   (issue_idx)
  );

  logic             alu_j_hit [DEPTH];
  logic             lsb_j_hit [DEPTH];
  logic             alu_k_hit [DEPTH];
  logic             lsb_k_hit [DEPTH];
  logic [DEPTH-1:0] qj_valid_nx;
  logic [DEPTH-1:0] qk_valid_nx;
  logic [31:0]      vj_nx [DEPTH];
  logic [31:0]      vk_nx [DEPTH];

  // Operand capture; the ALU CDB takes precedence when both carry the same tag.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      alu_j_hit[i]   = busy[i] && qj_valid[i] && cdb_alu_valid && (cdb_alu_rob == qj_q[i]);
      lsb_j_hit[i]   = busy[i] && qj_valid[i] && cdb_lsb_valid && (cdb_lsb_rob == qj_q[i]);
      alu_k_hit[i]   = busy[i] && qk_valid[i] && cdb_alu_valid && (cdb_alu_rob == qk_q[i]);
      lsb_k_hit[i]   = busy[i] && qk_valid[i] && cdb_lsb_valid && (cdb_lsb_rob == qk_q[i]);
      qj_valid_nx[i] = qj_valid[i] && !(alu_j_hit[i] || lsb_j_hit[i]);
      qk_valid_nx[i] = qk_valid[i] && !(alu_k_hit[i] || lsb_k_hit[i]);
      vj_nx[i]       = alu_j_hit[i] ? cdb_alu_result : (lsb_j_hit[i] ? cdb_lsb_result : vj_q[i]);
      vk_nx[i]       = alu_k_hit[i] ? cdb_alu_result : (lsb_k_hit[i] ? cdb_lsb_result : vk_q[i]);
    end
  end

  logic        disp_alu_j;
  logic        disp_lsb_j;
  logic        disp_alu_k;
  logic        disp_lsb_k;
  logic        disp_j_pend;
  logic        disp_k_pend;
  logic [31:0] disp_j_val;
  logic [31:0] disp_k_val;

  // Same-cycle bypass so a dispatch never misses a broadcast it races with.
  always_comb begin
    disp_alu_j  = disp_qj_valid && cdb_alu_valid && (cdb_alu_rob == disp_qj);
    disp_lsb_j  = disp_qj_valid && cdb_lsb_valid && (cdb_lsb_rob == disp_qj);
    disp_alu_k  = disp_qk_valid && cdb_alu_valid && (cdb_alu_rob == disp_qk);
    disp_lsb_k  = disp_qk_valid && cdb_lsb_valid && (cdb_lsb_rob == disp_qk);
    disp_j_pend = disp_qj_valid && !(disp_alu_j || disp_lsb_j);
    disp_k_pend = disp_qk_valid && !(disp_alu_k || disp_lsb_k);
    disp_j_val  = disp_alu_j ? cdb_alu_result : (disp_lsb_j ? cdb_lsb_result : disp_vj);
    disp_k_val  = disp_alu_k ? cdb_alu_result : (disp_lsb_k ? cdb_lsb_result : disp_vk);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      qj_valid   <= '0;
      qk_valid   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        rob_q[i] <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      alu_sgn    <= 1'b0;
      alu_opcode <= '0;
      alu_lhs    <= '0;
      alu_rhs    <= '0;
      alu_imm    <= '0;
      alu_pc     <= '0;
      alu_rob    <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy    <= '0;
        alu_sgn <= 1'b0;
      end else begin
        qj_valid <= qj_valid_nx;
        qk_valid <= qk_valid_nx;
        for (int i = 0; i < DEPTH; i++) begin
          vj_q[i] <= vj_nx[i];
          vk_q[i] <= vk_nx[i];
        end

        if (issue_found) begin
          alu_sgn           <= 1'b1;
          alu_opcode        <= op_q[issue_idx];
          alu_lhs           <= vj_q[issue_idx];
          alu_rhs           <= vk_q[issue_idx];
          alu_imm           <= imm_q[issue_idx];
          alu_pc            <= pc_q[issue_idx];
          alu_rob           <= rob_q[issue_idx];
          busy[issue_idx]   <= 1'b0;
        end else begin
          alu_sgn <= 1'b0;
        end

        // The free slot is never busy, so it cannot collide with the issue or snoop updates.
        if (disp_valid && free_found) begin
          busy[free_idx]     <= 1'b1;
          op_q[free_idx]     <= disp_opcode;
          qj_valid[free_idx] <= disp_j_pend;
          qj_q[free_idx]     <= disp_qj;
          vj_q[free_idx]     <= disp_j_val;
          qk_valid[free_idx] <= disp_k_pend;
          qk_q[free_idx]     <= disp_qk;
          vk_q[free_idx]     <= disp_k_val;
          imm_q[free_idx]    <= disp_imm;
          pc_q[free_idx]     <= disp_pc;
          rob_q[free_idx]    <= disp_rob;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// tb/tb_rs_alu_scheduler.sv - self-checking bench for rs_alu_scheduler against a behavioural model
module tb_rs_alu_scheduler;
  import rs_alu_scheduler_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int ROB_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             flush;
  logic             disp_valid;
  logic [5:0]       disp_opcode;
  logic             disp_qj_valid;
  logic [ROB_W-1:0] disp_qj;
  logic [31:0]      disp_vj;
  logic             disp_qk_valid;
  logic [ROB_W-1:0] disp_qk;
  logic [31:0]      disp_vk;
  logic [31:0]      disp_imm;
  logic [31:0]      disp_pc;
  logic [ROB_W-1:0] disp_rob;
  logic             rs_full;
  logic             cdb_alu_valid;
  logic [ROB_W-1:0] cdb_alu_rob;
  logic [31:0]      cdb_alu_result;
  logic             cdb_lsb_valid;
  logic [ROB_W-1:0] cdb_lsb_rob;
  logic [31:0]      cdb_lsb_result;
  logic             alu_sgn;
  logic [5:0]       alu_opcode;
  logic [31:0]      alu_lhs;
  logic [31:0]      alu_rhs;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_pc;
  logic [ROB_W-1:0] alu_rob;

  rs_alu_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode),
    .disp_qj_valid(disp_qj_valid), .disp_qj(disp_qj), .disp_vj(disp_vj),
    .disp_qk_valid(disp_qk_valid), .disp_qk(disp_qk), .disp_vk(disp_vk),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob(disp_rob),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_result(cdb_alu_result),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_result(cdb_lsb_result),
    .alu_sgn(alu_sgn), .alu_opcode(alu_opcode), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob(alu_rob)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an unordered pool of waiting instructions, each holding
  // its two operands as either a value or a pending producer tag.
  typedef struct {
    logic             busy;
    logic [5:0]       op;
    logic             jw;
    logic [ROB_W-1:0] jt;
    logic [31:0]      jv;
    logic             kw;
    logic [ROB_W-1:0] kt;
    logic [31:0]      kv;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob;
  } slot_t;

  slot_t            pool [DEPTH];
  logic             e_sgn;
  logic [5:0]       e_op;
  logic [31:0]      e_lhs, e_rhs, e_imm, e_pc;
  logic [ROB_W-1:0] e_rob;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) pool[i].busy = 1'b0;
    e_sgn = 0; e_op = 0; e_lhs = 0; e_rhs = 0; e_imm = 0; e_pc = 0; e_rob = 0;
  endtask

  function automatic bit model_full();
    for (int i = 0; i < DEPTH; i++) if (!pool[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Value seen for an operand waiting on tag t, given this cycle's broadcasts.
  task automatic listen(inout logic wait_f, input logic [ROB_W-1:0] t, inout logic [31:0] v);
    if (!wait_f) return;
    if (cdb_alu_valid && cdb_alu_rob == t) begin wait_f = 0; v = cdb_alu_result; end
    else if (cdb_lsb_valid && cdb_lsb_rob == t) begin wait_f = 0; v = cdb_lsb_result; end
  endtask

  task automatic model_edge();
    int pick;
    int hole;
    slot_t n;
    if (!rst) begin model_reset(); return; end
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) pool[i].busy = 1'b0;
      e_sgn = 0;
      return;
    end
    pick = -1; hole = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick < 0 && pool[i].busy && !pool[i].jw && !pool[i].kw) pick = i;
      if (hole < 0 && !pool[i].busy) hole = i;
    end
    if (pick >= 0) begin
      e_sgn = 1; e_op = pool[pick].op; e_lhs = pool[pick].jv; e_rhs = pool[pick].kv;
      e_imm = pool[pick].imm; e_pc = pool[pick].pc; e_rob = pool[pick].rob;
      pool[pick].busy = 1'b0;
    end else begin
      e_sgn = 0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (pool[i].busy) begin
        listen(pool[i].jw, pool[i].jt, pool[i].jv);
        listen(pool[i].kw, pool[i].kt, pool[i].kv);
      end
    end
    if (disp_valid && hole >= 0) begin
      n.busy = 1; n.op = disp_opcode; n.imm = disp_imm; n.pc = disp_pc; n.rob = disp_rob;
      n.jw = disp_qj_valid; n.jt = disp_qj; n.jv = disp_vj;
      n.kw = disp_qk_valid; n.kt = disp_qk; n.kv = disp_vk;
      listen(n.jw, n.jt, n.jv);
      listen(n.kw, n.kt, n.kv);
      pool[hole] = n;
    end
  endtask

  task automatic compare_all(input string where);
    expect_eq({where, ".sgn"},     alu_sgn,    e_sgn);
    expect_eq({where, ".opcode"},  alu_opcode, e_op);
    expect_eq({where, ".lhs"},     alu_lhs,    e_lhs);
    expect_eq({where, ".rhs"},     alu_rhs,    e_rhs);
    expect_eq({where, ".imm"},     alu_imm,    e_imm);
    expect_eq({where, ".pc"},      alu_pc,     e_pc);
    expect_eq({where, ".rob"},     alu_rob,    e_rob);
    expect_eq({where, ".rs_full"}, rs_full,    model_full());
  endtask

  task automatic tick(input string where);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(where);
  endtask

  task automatic idle_inputs();
    disp_valid = 0; flush = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0;
  endtask

  task automatic set_disp(input logic [5:0] op, input logic jw, input logic [3:0] jt, input logic [31:0] jv,
                          input logic kw, input logic [3:0] kt, input logic [31:0] kv, input logic [3:0] rob);
    disp_valid = 1; disp_opcode = op;
    disp_qj_valid = jw; disp_qj = jt; disp_vj = jv;
    disp_qk_valid = kw; disp_qk = kt; disp_vk = kv;
    disp_rob = rob; disp_imm = $urandom; disp_pc = $urandom;
  endtask

  initial begin
    rst = 1; rdy = 1;
    idle_inputs();
    disp_opcode = 0; disp_qj_valid = 0; disp_qj = 0; disp_vj = 0;
    disp_qk_valid = 0; disp_qk = 0; disp_vk = 0; disp_imm = 0; disp_pc = 0; disp_rob = 0;
    cdb_alu_rob = 0; cdb_alu_result = 0; cdb_lsb_rob = 0; cdb_lsb_result = 0;
    #2 rst = 0;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk) rst = 1;

    // Fully ready ADD issues one edge after dispatch.
    set_disp(ADD, 0, 0, 5, 0, 0, 7, 3);
    tick("add_disp");
    idle_inputs();
    tick("add_issue");
    expect_eq("add_sgn", alu_sgn, 1);
    expect_eq("add_lhs", alu_lhs, 5);
    expect_eq("add_rhs", alu_rhs, 7);
    expect_eq("add_rob", alu_rob, 3);
    expect_eq("add_op",  alu_opcode, ADD);
    tick("add_after");
    expect_eq("add_pulse_end", alu_sgn, 0);

    // SUB waits for tag 2 from the LSB CDB.
    set_disp(SUB, 1, 2, 0, 0, 0, 1, 4);
    tick("sub_disp");
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick("sub_wait");
      expect_eq("sub_no_early_issue", alu_sgn, 0);
    end
    cdb_lsb_valid = 1; cdb_lsb_rob = 2; cdb_lsb_result = 10;
    tick("sub_cdb");
    expect_eq("sub_not_same_cycle", alu_sgn, 0);
    idle_inputs();
    tick("sub_issue");
    expect_eq("sub_sgn", alu_sgn, 1);
    expect_eq("sub_lhs", alu_lhs, 10);
    expect_eq("sub_rhs", alu_rhs, 1);

    // Same-cycle bypass of the ALU CDB into dispatch.
    set_disp(OR_OP, 0, 0, 32'h1234, 1, 6, 0, 7);
    cdb_alu_valid = 1; cdb_alu_rob = 6; cdb_alu_result = 32'hFFFF_FFFF;
    tick("byp_disp");
    idle_inputs();
    tick("byp_issue");
    expect_eq("byp_sgn", alu_sgn, 1);
    expect_eq("byp_rhs", alu_rhs, 32'hFFFF_FFFF);

    // Fill every slot waiting on tag 9, then release them together.
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(XOR_OP, 1, 9, 0, 0, 0, i, i[3:0]);
      tick("fill");
    end
    expect_eq("fill_full", rs_full, 1);
    set_disp(ADD, 0, 0, 1, 0, 0, 1, 15);
    tick("fill_overflow");
    idle_inputs();
    cdb_alu_valid = 1; cdb_alu_rob = 9; cdb_alu_result = 32'h99;
    tick("fill_cdb");
    idle_inputs();
    for (int k = 0; k < DEPTH; k++) begin
      tick("drain");
      expect_eq("drain_sgn", alu_sgn, 1);
      expect_eq("drain_order", alu_rob, k);
      if (k == 0) expect_eq("drain_full_release", rs_full, 0);
    end
    tick("drain_done");
    expect_eq("drain_empty_sgn", alu_sgn, 0);

    // Flush with a concurrent dispatch.
    for (int i = 0; i < 4; i++) begin
      set_disp(SLT, 1, 4'(10 + i), 0, 0, 0, 0, 4'(i));
      tick("flush_fill");
    end
    set_disp(ADD, 0, 0, 3, 0, 0, 4, 8);
    flush = 1;
    tick("flush");
    expect_eq("flush_sgn", alu_sgn, 0);
    expect_eq("flush_full", rs_full, 0);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      cdb_alu_valid = 1; cdb_alu_rob = 4'(10 + i); cdb_alu_result = 32'hDEAD;
      tick("flush_stale_cdb");
      expect_eq("flush_no_issue", alu_sgn, 0);
    end
    idle_inputs();
    tick("flush_tail");
    expect_eq("flush_tail_sgn", alu_sgn, 0);

    // Stall with rdy=0, then asynchronous reset mid-cycle.
    set_disp(BEQ, 0, 0, 11, 0, 0, 11, 5);
    tick("stall_disp");
    idle_inputs();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      expect_eq("stall_no_issue", alu_sgn, 0);
    end
    @(negedge clk);
    rst = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    expect_eq("async_rst_lhs", alu_lhs, 0);
    @(negedge clk);
    rst = 1; rdy = 1;
    for (int i = 0; i < 2; i++) begin
      tick("post_rst");
      expect_eq("post_rst_no_issue", alu_sgn, 0);
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 59) == 0);
      disp_valid    = ($urandom_range(0, 9) < 6);
      disp_opcode   = 6'($urandom_range(0, 15));
      disp_qj_valid = $urandom_range(0, 1);
      disp_qj       = 4'($urandom);
      disp_vj       = $urandom;
      disp_qk_valid = $urandom_range(0, 1);
      disp_qk       = 4'($urandom);
      disp_vk       = $urandom;
      disp_imm      = $urandom;
      disp_pc       = $urandom;
      disp_rob      = 4'($urandom);
      cdb_alu_valid = ($urandom_range(0, 9) < 4);
      cdb_alu_rob   = 4'($urandom);
      cdb_alu_result = $urandom;
      cdb_lsb_valid = ($urandom_range(0, 9) < 4);
      cdb_lsb_rob   = 4'($urandom);
      cdb_lsb_result = $urandom;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_alu_scheduler.md
Name: rs_alu_scheduler

Overview:
- Reservation station plus issue scheduler that owns and sequences the shared integer ALU.
- Accepts decoded ALU and branch ops from dispatch and holds up to DEPTH entries.
- Captures missing operands by snooping both CDBs (ALU and LSB).
- Each cycle, issues at most one operand-ready entry to the ALU on its RS_* inputs; the ALU result returns on the ALU CDB tagged with the entry's ROB name.

Parameters:
- DEPTH, 8: number of RS entries (power of two, 2..16).
- IDX_W, 3: log2(DEPTH), entry index width.
- ROB_W, 4: ROB tag width; matches the ROB entry define.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready/clock-enable; when 0, all state holds.
- flush  in  1  mispredict flush; clears all entries.
- disp_valid  in  1  dispatch request this cycle.
- disp_opcode  in  6  ALU opcode, same encoding as the ALU's opcode defines.
- disp_qj_valid  in  1  lhs waits on a ROB tag.
- disp_qj  in  ROB_W  lhs producer tag.
- disp_vj  in  32  lhs value, used when qj_valid=0.
- disp_qk_valid  in  1  rhs waits on a ROB tag.
- disp_qk  in  ROB_W  rhs producer tag.
- disp_vk  in  32  rhs value; for I-type ops, decode places the immediate here with qk_valid=0.
- disp_imm  in  32  immediate, passed through for branch/JALR target use.
- disp_pc  in  32  instruction PC.
- disp_rob  in  ROB_W  destination ROB tag.
- rs_full  out  1  no free entry (combinational from valid bits).
- cdb_alu_valid  in  1  ALU CDB broadcast.
- cdb_alu_rob  in  ROB_W  ALU CDB tag.
- cdb_alu_result  in  32  ALU CDB value.
- cdb_lsb_valid  in  1  LSB CDB broadcast.
- cdb_lsb_rob  in  ROB_W  LSB CDB tag.
- cdb_lsb_result  in  32  LSB CDB value.
- alu_sgn  out  1  issue strobe to the ALU (RS_sgn).
- alu_opcode  out  6  RS_opcode.
- alu_lhs  out  32  RS_lhs.
- alu_rhs  out  32  RS_rhs.
- alu_imm  out  32  RS_imm.
- alu_pc  out  32  RS_pc.
- alu_rob  out  ROB_W  RS_ROB_entry.

Behaviour:
- Reset (rst=0, asynchronous):
  - All entry valid bits = 0.
  - alu_sgn = 0; alu_opcode, alu_lhs, alu_rhs, alu_imm, alu_pc and alu_rob = 0.
  - rs_full = 0.
  - Reset mid-operation discards all entries with no issue.
- rdy=0: no state update; all outputs hold their last value.
- Per-entry state: busy, opcode, qj_valid/qj/vj, qk_valid/qk/vk, imm, pc, rob.
- An entry is ready when busy=1, qj_valid=0 and qk_valid=0.
- CDB snoop, every clk with rdy=1:
  - For each busy entry, a valid CDB whose tag equals a pending qj (or qk) clears that q_valid and writes the CDB value into vj (or vk).
  - Both operands may resolve in the same cycle, from the same or different CDBs.
  - If both CDBs carry the same tag (illegal), the ALU CDB wins.
- Dispatch:
  - Taken at the edge when disp_valid=1, rs_full=0 and flush=0.
  - Written into the lowest-index free entry.
  - Same-cycle bypass: if disp_qj (or disp_qk) matches a valid CDB tag in that cycle, the entry is stored with q_valid=0 and the CDB value.
  - disp_valid while rs_full=1 is ignored, and no entry is written. rs_full is computed before this cycle's issue frees a slot.
- Issue selection:
  - Combinational pick of the lowest-index ready entry, using state as of the cycle start.
  - At the edge, alu_* are registered from the selected entry, alu_sgn=1, and that entry's busy is cleared.
  - With no ready entry, alu_sgn=0 and the other alu_* outputs hold.
  - alu_sgn is a one-cycle pulse per issued entry.
  - An entry made ready by a CDB in cycle N is first selectable in cycle N+1.
- Latency:
  - A fully-ready dispatch sampled at edge E is issued at edge E+1 (alu_sgn high during cycle E+1..E+2).
  - The ALU is combinational, so the CDB result appears in that same cycle.
- Simultaneous dispatch and issue in one cycle: both take effect. A freed slot becomes visible to rs_full in the next cycle.
- Flush:
  - Synchronous, dominates dispatch and issue.
  - At the edge: all busy cleared, alu_sgn=0.
  - Dispatch in the flush cycle is dropped.
- Widths: tags compare over the full ROB_W bits; no arithmetic beyond the index encoders.

Decomposition:
- Shared defines file: opcode macros (ADD..S_OP), ROBENTRY range, RS_DEPTH and RS_IDX_W.
- One sub-module, rs_ready_picker:
  - Parameterised DEPTH-bit lowest-index priority encoder.
  - Outputs found flag and index.
  - Instantiated twice: once on ~busy (free slot) and once on ready (issue).

Test Plan:
- Reset then dispatch ADD, vj=5, vk=7, both ready, rob=3 -> alu_sgn=1 one cycle later with lhs=5, rhs=7, rob=3, opcode=ADD; alu_sgn=0 the following cycle.
- Dispatch SUB with qj=2 pending, vk=1; three cycles later cdb_lsb_valid with rob=2, result=10 -> issue in the next cycle with lhs=10, rhs=1; no issue before the CDB.
- Dispatch with disp_qk=6 while cdb_alu_valid, rob=6, result=0xFFFF_FFFF in the same cycle -> entry stored ready; issue next edge with rhs=0xFFFF_FFFF.
- Fill 8 entries all waiting on tag 9 -> rs_full=1 and a 9th dispatch is ignored. One CDB with rob=9 -> entries issue one per cycle in index order 0..7; rs_full deasserts after the first issue.
- Four entries pending plus flush asserted together with disp_valid -> next cycle all busy=0, alu_sgn=0, rs_full=0; a later CDB for the old tags produces no issue.
- Ready entry with rdy held 0 for 3 cycles, then rst pulsed low asynchronously mid-cycle -> no issue during the stall; outputs go to 0 immediately on rst and the entry is gone.
